nmr_voter_monitor: RTL and testbench
====================================

NMR_VOTER_MONITOR -- requirements
Module: nmr_voter_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 3, meaning number of redundant channels; legal values 3 or 5 only.
REQ-002 SHALL have parameter DATA_W, default 97, meaning width of one channel word: PC 32 + ALUResult 32 + RD2 32 + MemWrite 1.
REQ-003 SHALL have parameter FAULT_THRESH, default 4, meaning consecutive mismatches before a channel is declared faulty; range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port valid_i, input, 1 bit: channel words are valid for comparison this cycle.
REQ-007 SHALL have port ch_data_i, input, N_CH*DATA_W bits: channel words packed, with channel 0 in the LSBs.
REQ-008 SHALL have port voted_o, output, DATA_W bits: registered bitwise-majority word.
REQ-009 SHALL have port voted_valid_o, output, 1 bit: voted_o is valid.
REQ-010 SHALL have port mismatch_o, output, N_CH bits: registered per-channel disagreement flags for the last compare.
REQ-011 SHALL have port fault_o, output, N_CH bits: sticky per-channel fault flags.
REQ-012 SHALL have port resync_req_o, output, 1 bit: resynchronisation request to the core controller.
REQ-013 SHALL have port resync_ack_i, input, 1 bit: the controller has resynchronised all channels.
REQ-014 SHALL have port fail_o, output, 1 bit: unrecoverable state.
REQ-015 SHALL have port state_o, output, 2 bits: current FSM state.
REQ-016 SHALL have port err_count_o, output, 16 bits: total mismatch events (see Configuration).

Function
REQ-017 SHALL compute each voted bit as 1 iff the count of 1s across channels is greater than N_CH/2, with 1-cycle latency.
REQ-018 SHALL set voted_valid_o equal to valid_i delayed by 1 cycle; voted_o and mismatch_o SHALL hold their values when valid_i=0.
REQ-019 SHALL set mismatch_o[i] when channel i's word differs from the combinational majority word in any bit.
REQ-020 SHALL keep a per-channel consecutive-mismatch counter: on a valid mismatch it increments, saturating at FAULT_THRESH; on a valid match it clears; on valid_i=0 it holds.
REQ-021 SHALL set fault_o[i] in the cycle its counter reaches FAULT_THRESH; fault_o[i] SHALL then stay set until a resync completes or reset.
REQ-022 SHALL have FSM states NORMAL=0, DEGRADED=1, RESYNC=2, FAIL=3.
REQ-023 SHALL move NORMAL->DEGRADED when any fault_o bit is set.
REQ-024 SHALL move DEGRADED->RESYNC on the next cycle and assert resync_req_o while in RESYNC.
REQ-025 SHALL, in RESYNC, freeze all counters while voting continues, and hold resync_req_o until resync_ack_i=1 is sampled.
REQ-026 SHALL, on that sample, clear all counters and fault_o bits and move to NORMAL.
REQ-027 SHALL, when resync_ack_i and a new mismatch coincide, let the ack win: the counters clear and that mismatch is discarded.
REQ-028 SHALL ignore resync_ack_i outside RESYNC.
REQ-029 SHALL move from any state to FAIL when the count of set fault_o bits exceeds N_CH/2, or when a valid compare has no channel equal to the majority word.
REQ-030 SHALL keep FAIL sticky until reset, with fail_o=1, resync_req_o=0 and voting continuing.

Reset
REQ-031 SHALL, on rst=1, asynchronously clear voted_o, voted_valid_o, mismatch_o, fault_o, all counters, resync_req_o, fail_o and err_count_o, and set state to NORMAL.
REQ-032 SHALL, on reset during RESYNC, drop resync_req_o immediately without waiting for the clock.

Configuration
REQ-033 SHALL, when NMR_ERR_COUNT_EN is defined, increment err_count_o by 1 for each valid cycle with any mismatch_o bit set, saturating at 16'hFFFF, including in RESYNC and FAIL.
REQ-034 SHALL, without NMR_ERR_COUNT_EN, tie err_count_o to 0 and omit its register.

Structure
REQ-035 SHALL place the state enum/encodings, a clog2 function, and the legality check for N_CH and FAULT_THRESH in the shared package nmr_pkg.
REQ-036 SHALL place the majority and word-compare logic in the combinational sub-module nmr_majority, instantiated once.

Verification
REQ-037 SHALL cover: N_CH=3, channels 0xA/0xA/0x5 with valid -> next cycle voted_o=0xA, mismatch_o=3'b100, state NORMAL.
REQ-038 SHALL cover: channel 2 mismatches 4 consecutive valid cycles -> fault_o=3'b100 after the 4th, DEGRADED, then RESYNC with resync_req_o=1; a match on cycle 3 instead leaves fault_o=0.
REQ-039 SHALL cover: in RESYNC, resync_ack_i=1 for one cycle -> fault_o=0, counters=0, state NORMAL; with a simultaneous mismatch, the counter stays 0.
REQ-040 SHALL cover: N_CH=5, channels 0x1/0x2/0x4/0x8/0x10 -> voted_o=0, no channel equal, fail_o=1 and state FAIL held until rst.
REQ-041 SHALL cover: rst pulsed mid-RESYNC, between clock edges -> resync_req_o=0 immediately and all outputs at reset values.
REQ-042 SHALL cover: with NMR_ERR_COUNT_EN, 70000 mismatching valid cycles -> err_count_o=16'hFFFF; without it -> err_count_o=0.

Source files
------------

// File: rtl/nmr_pkg.sv
// Shared types and helpers for the N-modular-redundancy voter/monitor.
// FSM state encoding, a constant clog2, and the parameter legality check.
package nmr_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_RESYNC   = 2'd2,
        ST_FAIL     = 2'd3
    } nmr_state_e;

    function automatic int unsigned nmr_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    function automatic bit nmr_params_legal(input int unsigned n_ch,
                                            input int unsigned thresh);
        return ((n_ch == 3) || (n_ch == 5)) && (thresh >= 1) && (thresh <= 15);
    endfunction

endpackage

// File: rtl/nmr_majority.sv
// Combinational bitwise-majority vote across N_CH channel words, plus a
// per-channel "differs from majority" flag.
module nmr_majority
    import nmr_pkg::*;
#(
    parameter int unsigned N_CH   = 3,
    parameter int unsigned DATA_W = 97
) (
    input  logic [N_CH*DATA_W-1:0] ch_data_i,
    output logic [DATA_W-1:0]      maj_o,
    output logic [N_CH-1:0]        neq_o
);

    localparam int unsigned CW = nmr_clog2(N_CH + 1);

    logic [CW-1:0] ones;

    always_comb begin
        maj_o = '0;
        neq_o = '0;
        ones  = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            ones = '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                ones = ones + CW'(ch_data_i[c*DATA_W + b]);
            end
            maj_o[b] = (ones > CW'(N_CH / 2));
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
            neq_o[c] = (ch_data_i[c*DATA_W +: DATA_W] != maj_o);
        end
    end

endmodule

// File: rtl/nmr_voter_monitor.sv
// Registered majority voter with per-channel fault tracking and resync FSM.
// Optional macro NMR_ERR_COUNT_EN enables the saturating mismatch-event counter.
module nmr_voter_monitor
    import nmr_pkg::*;
#(
    parameter int unsigned N_CH         = 3,
    parameter int unsigned DATA_W       = 97,
    parameter int unsigned FAULT_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [N_CH*DATA_W-1:0] ch_data_i,
    output logic [DATA_W-1:0]      voted_o,
    output logic                   voted_valid_o,
    output logic [N_CH-1:0]        mismatch_o,
    output logic [N_CH-1:0]        fault_o,
    output logic                   resync_req_o,
    input  logic                   resync_ack_i,
    output logic                   fail_o,
    output logic [1:0]             state_o,
    output logic [15:0]            err_count_o
);

    localparam int unsigned CNT_W = nmr_clog2(FAULT_THRESH + 1);
    localparam int unsigned NF_W  = nmr_clog2(N_CH + 1);

    if (!nmr_params_legal(N_CH, FAULT_THRESH)) begin : g_bad_params
        $error("nmr_voter_monitor: N_CH must be 3 or 5, FAULT_THRESH 1..15");
    end

    logic [DATA_W-1:0] maj;
    logic [N_CH-1:0]   neq;

    nmr_majority #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) u_majority (
        .ch_data_i (ch_data_i),
        .maj_o     (maj),
        .neq_o     (neq)
    );

    nmr_state_e        state_q;
    logic [DATA_W-1:0] voted_q;
    logic              voted_valid_q;
    logic [N_CH-1:0]   mismatch_q;
    logic [N_CH-1:0]   fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic              resync_req_q;
    logic              fail_q;
    logic [NF_W-1:0]   n_fault;
    logic              fail_cond;

    // Counters freeze in RESYNC; an ack there clears them and drops any coincident mismatch.
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (state_q == ST_RESYNC) begin
            if (resync_ack_i) begin
                for (int unsigned i = 0; i < N_CH; i++) cnt_d[i] = '0;
                fault_d = '0;
            end
        end else if (valid_i) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!neq[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_W'(FAULT_THRESH)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                fault_d[i] = fault_q[i] | (cnt_d[i] == CNT_W'(FAULT_THRESH));
            end
        end
    end

    always_comb begin
        n_fault = '0;
        for (int unsigned i = 0; i < N_CH; i++) n_fault = n_fault + NF_W'(fault_q[i]);
        fail_cond = (n_fault > NF_W'(N_CH / 2)) || (valid_i && (&neq));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            voted_q       <= '0;
            voted_valid_q <= 1'b0;
            mismatch_q    <= '0;
            fault_q       <= '0;
            cnt_q         <= '{default: '0};
            resync_req_q  <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            voted_valid_q <= valid_i;
            if (valid_i) begin
                voted_q    <= maj;
                mismatch_q <= neq;
            end
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            if (fail_cond || (state_q == ST_FAIL)) begin
                state_q      <= ST_FAIL;
                resync_req_q <= 1'b0;
                fail_q       <= 1'b1;
            end else begin
                case (state_q)
                    ST_NORMAL: begin
                        if (|fault_q) state_q <= ST_DEGRADED;
                    end
                    ST_DEGRADED: begin
                        state_q      <= ST_RESYNC;
                        resync_req_q <= 1'b1;
                    end
                    ST_RESYNC: begin
                        if (resync_ack_i) begin
                            state_q      <= ST_NORMAL;
                            resync_req_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NMR_ERR_COUNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (valid_i && (|neq) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

    assign voted_o       = voted_q;
    assign voted_valid_o = voted_valid_q;
    assign mismatch_o    = mismatch_q;
    assign fault_o       = fault_q;
    assign resync_req_o  = resync_req_q;
    assign fail_o        = fail_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_nmr_voter_monitor.sv
// Scoreboard bench for nmr_voter_monitor: a 3-channel and a 5-channel instance
// share stimulus; a behavioural model predicts every cycle (honours NMR_ERR_COUNT_EN).
module tb_nmr_voter_monitor;

    localparam int DW = 97;
    localparam int TH = 4;

    typedef logic [DW-1:0]      word_t;
    typedef logic [4:0][DW-1:0] words_t;

    typedef struct packed {
        logic        vv;
        word_t       voted;
        logic [4:0]  mism;
        logic [4:0]  flt;
        logic        req;
        logic        fail;
        logic [1:0]  st;
        logic [15:0] err;
        logic [4:0][3:0] cnt;
    } mdl_t;

    typedef struct packed {
        mdl_t m3;
        mdl_t m5;
    } exp_t;

    logic clk, rst, valid, ack;
    logic [3*DW-1:0] d3;
    logic [5*DW-1:0] d5;

    word_t       voted3, voted5;
    logic        vv3, vv5, req3, req5, fail3, fail5;
    logic [2:0]  mism3, flt3;
    logic [4:0]  mism5, flt5;
    logic [1:0]  st3, st5;
    logic [15:0] err3, err5;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    mdl_t m3, m5;
    words_t w;
    exp_t e_mon;

    nmr_voter_monitor #(.N_CH(3), .DATA_W(DW), .FAULT_THRESH(TH)) u_dut3 (
        .clk(clk), .rst(rst), .valid_i(valid), .ch_data_i(d3),
        .voted_o(voted3), .voted_valid_o(vv3), .mismatch_o(mism3), .fault_o(flt3),
        .resync_req_o(req3), .resync_ack_i(ack), .fail_o(fail3), .state_o(st3),
        .err_count_o(err3)
    );

    nmr_voter_monitor #(.N_CH(5), .DATA_W(DW), .FAULT_THRESH(TH)) u_dut5 (
        .clk(clk), .rst(rst), .valid_i(valid), .ch_data_i(d5),
        .voted_o(voted5), .voted_valid_o(vv5), .mismatch_o(mism5), .fault_o(flt5),
        .resync_req_o(req5), .resync_ack_i(ack), .fail_o(fail5), .state_o(st5),
        .err_count_o(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one clock of the voter for an n-channel system.
    function automatic mdl_t mstep(mdl_t s, int n, bit v, words_t wd, bit ak);
        mdl_t r;
        word_t maj;
        logic [4:0] neq;
        logic [4:0] all;
        int ones, nf;
        r   = s;
        maj = '0;
        neq = '0;
        all = 5'((1 << n) - 1);
        for (int b = 0; b < DW; b++) begin
            ones = 0;
            for (int i = 0; i < n; i++) ones += int'(wd[i][b]);
            maj[b] = (ones > n / 2);
        end
        for (int i = 0; i < n; i++) neq[i] = (wd[i] != maj);
        nf = 0;
        for (int i = 0; i < n; i++) nf += int'(s.flt[i]);
        r.vv = v;
        if (v) begin
            r.voted = maj;
            r.mism  = neq;
        end
        if (s.st == 2'd2) begin
            if (ak) begin
                r.cnt = '0;
                r.flt = '0;
            end
        end else if (v) begin
            for (int i = 0; i < n; i++) begin
                if (!neq[i])               r.cnt[i] = 4'd0;
                else if (s.cnt[i] < 4'(TH)) r.cnt[i] = s.cnt[i] + 4'd1;
                if (r.cnt[i] == 4'(TH)) r.flt[i] = 1'b1;
            end
        end
`ifdef NMR_ERR_COUNT_EN
        if (v && (neq != 5'd0) && (s.err != 16'hFFFF)) r.err = s.err + 16'd1;
`endif
        if ((s.st == 2'd3) || (nf > n / 2) || (v && (neq == all))) r.st = 2'd3;
        else if (s.st == 2'd0) r.st = (s.flt != 5'd0) ? 2'd1 : 2'd0;
        else if (s.st == 2'd1) r.st = 2'd2;
        else r.st = ak ? 2'd0 : 2'd2;
        r.req  = (r.st == 2'd2);
        r.fail = (r.st == 2'd3);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, " d3.voted"}, 128'(voted3), 128'(e.m3.voted));
        chk({tag, " d3.vvalid"}, 128'(vv3), 128'(e.m3.vv));
        chk({tag, " d3.mismatch"}, 128'(mism3), 128'(e.m3.mism[2:0]));
        chk({tag, " d3.fault"}, 128'(flt3), 128'(e.m3.flt[2:0]));
        chk({tag, " d3.req"}, 128'(req3), 128'(e.m3.req));
        chk({tag, " d3.fail"}, 128'(fail3), 128'(e.m3.fail));
        chk({tag, " d3.state"}, 128'(st3), 128'(e.m3.st));
        chk({tag, " d3.err"}, 128'(err3), 128'(e.m3.err));
        chk({tag, " d5.voted"}, 128'(voted5), 128'(e.m5.voted));
        chk({tag, " d5.vvalid"}, 128'(vv5), 128'(e.m5.vv));
        chk({tag, " d5.mismatch"}, 128'(mism5), 128'(e.m5.mism));
        chk({tag, " d5.fault"}, 128'(flt5), 128'(e.m5.flt));
        chk({tag, " d5.req"}, 128'(req5), 128'(e.m5.req));
        chk({tag, " d5.fail"}, 128'(fail5), 128'(e.m5.fail));
        chk({tag, " d5.state"}, 128'(st5), 128'(e.m5.st));
        chk({tag, " d5.err"}, 128'(err5), 128'(e.m5.err));
    endtask

    // Drive one cycle of stimulus from the current word set and queue the prediction.
    task automatic step(input bit v, input bit ak);
        exp_t e;
        @(negedge clk);
        valid = v;
        ack   = ak;
        d3    = {w[2], w[1], w[0]};
        d5    = w;
        m3    = mstep(m3, 3, v, w, ak);
        m5    = mstep(m5, 5, v, w, ak);
        e.m3  = m3;
        e.m5  = m5;
        q.push_back(e);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cmp(tag, '0);
        #1;
        rst = 1'b0;
        m3 = '0;
        m5 = '0;
    endtask

    task automatic set_all(input word_t v);
        for (int i = 0; i < 5; i++) w[i] = v;
    endtask

    function automatic word_t rnd_word();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst && (q.size() > 0)) begin
            e_mon = q.pop_front();
            cmp("cycle", e_mon);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        ack   = 1'b0;
        d3    = '0;
        d5    = '0;
        m3    = '0;
        m5    = '0;
        set_all('0);
        #23;
        cmp("por", '0);
        #4;
        rst = 1'b0;

        // Basic vote: channel 2 disagrees, then hold with valid low.
        set_all(word_t'('hA));
        w[2] = word_t'('h5);
        step(1, 0);
        step(0, 0);
        step(0, 0);

        // Mismatch run broken by a match on the third cycle: no fault.
        foreach (w[i]) w[i] = word_t'('hA);
        for (int k = 0; k < 4; k++) begin
            w[2] = (k == 2) ? word_t'('hA) : word_t'('h5);
            step(1, 0);
        end
        step(0, 0);

        // Four consecutive mismatches -> fault, DEGRADED, RESYNC; ack with coincident mismatch.
        w[2] = word_t'('h5);
        repeat (4) step(1, 0);
        repeat (3) step(0, 0);
        step(1, 1);
        repeat (3) step(1, 0);
        step(0, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        set_all(word_t'('hA));
        step(1, 1);
        step(0, 0);

        // Randomised traffic with sparse channel corruption and random acks.
        for (int k = 0; k < 400; k++) begin
            int c, b;
            set_all(rnd_word());
            if ($urandom_range(0, 3) == 0) begin
                c = $urandom_range(0, 4);
                b = $urandom_range(0, DW - 1);
                w[c][b] = ~w[c][b];
                if ($urandom_range(0, 3) == 0) begin
                    c = $urandom_range(0, 4);
                    b = $urandom_range(0, DW - 1);
                    w[c][b] = ~w[c][b];
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end
        do_reset("rst_after_random");

        // No channel agrees with the majority: FAIL, sticky across acks until reset.
        for (int i = 0; i < 5; i++) w[i] = word_t'(1 << i);
        step(1, 0);
        set_all(word_t'('h3));
        repeat (2) step(1, 1);
        repeat (2) step(0, 0);
        do_reset("rst_after_fail");

        // Reach RESYNC, then reset between edges.
        set_all(word_t'('hA));
        w[2] = word_t'('h5);
        repeat (4) step(1, 0);
        repeat (3) step(0, 0);
        do_reset("rst_mid_resync");

        // Long mismatching run to exercise error-count saturation.
        repeat (70000) step(1, 0);
        step(0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
